// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Request bundle layout and default widths live here.
package regfile_wb_arbiter_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;
  localparam int NQ    = 4;

  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_AW-1:0] wn;
    logic [WB_DW-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small per-source writeback queue with head output and
// a per-query "nonzero register is queued here" match vector.
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [AW-1:0]         wn_i,
  input  logic [DW-1:0]         wd_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW-1:0]         head_wn_o,
  output logic [DW-1:0]         head_wd_o,
  input  logic [NQ-1:0][AW-1:0] cmp_i,
  output logic [NQ-1:0]         hit_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] ent_wn_q [DEPTH];
  logic [DW-1:0] ent_wd_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign full_o    = cnt_q == CW'(DEPTH);
  assign empty_o   = cnt_q == '0;
  assign do_pop    = pop_i && !empty_o;
  assign head_wn_o = ent_wn_q[rd_q];
  assign head_wd_o = ent_wd_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      ent_wn_q[wr_q] <= wn_i;
      ent_wd_q[wr_q] <= wd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Walk only the occupied slots, oldest first
  always_comb begin
    hit_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int q = 0; q < NQ; q++) begin
        if (CW'(k) < cnt_q && cmp_i[q] != '0 &&
            ent_wn_q[rd_q + PW'(k)] == cmp_i[q])
          hit_o[q] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port
// between the EX result queue and the load/multi-cycle queue.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          v0_i,
  output logic          r0_o,
  input  logic [AW-1:0] wn0_i,
  input  logic [DW-1:0] wd0_i,
  input  logic          v1_i,
  output logic          r1_o,
  input  logic [AW-1:0] wn1_i,
  input  logic [DW-1:0] wd1_i,
  output logic          write_o,
  output logic [AW-1:0] wn_o,
  output logic [DW-1:0] wd_o,
  input  logic [AW-1:0] rn1_i,
  input  logic [AW-1:0] rn2_i,
  output logic          busy1_o,
  output logic          busy2_o,
  output logic          idle_o,
  output logic          hazard_o
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [1:0]            full, empty, push, pop;
  logic [AW-1:0]         hwn [2];
  logic [DW-1:0]         hwd [2];
  logic [NQ-1:0][AW-1:0] cmp;
  logic [NQ-1:0]         hit0, hit1, hit_os, hit;
  logic                  gsel;
  logic                  write_q, write_d;
  logic                  last_q, last_d;
  logic                  haz_q, haz_d;
  logic [AW-1:0]         wn_q, wn_d;
  logic [DW-1:0]         wd_q, wd_d;

  // Query slots: 0=rn1, 1=rn2, 2=wn0, 3=wn1
  assign cmp  = {wn1_i, wn0_i, rn2_i, rn1_i};
  assign r0_o = !full[0];
  assign r1_o = !full[1];
  assign push = {v1_i && !full[1], v0_i && !full[0]};

  // last_q names the port granted last; reset value favours port 0
  assign pop[0] = !empty[0] && (empty[1] || last_q);
  assign pop[1] = !empty[1] && (empty[0] || !last_q);
  assign gsel   = pop[1];

  regfile_wb_arbiter_wb_fifo #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) u_q0 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push[0]),
    .wn_i     (wn0_i),
    .wd_i     (wd0_i),
    .pop_i    (pop[0]),
    .full_o   (full[0]),
    .empty_o  (empty[0]),
    .head_wn_o(hwn[0]),
    .head_wd_o(hwd[0]),
    .cmp_i    (cmp),
    .hit_o    (hit0)
  );

  regfile_wb_arbiter_wb_fifo #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) u_q1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push[1]),
    .wn_i     (wn1_i),
    .wd_i     (wd1_i),
    .pop_i    (pop[1]),
    .full_o   (full[1]),
    .empty_o  (empty[1]),
    .head_wn_o(hwn[1]),
    .head_wd_o(hwd[1]),
    .cmp_i    (cmp),
    .hit_o    (hit1)
  );

  always_comb begin
    hit_os = '0;
    for (int q = 0; q < NQ; q++)
      hit_os[q] = write_q && cmp[q] != ZERO && wn_q == cmp[q];
  end

  assign hit      = hit0 | hit1 | hit_os;
  assign busy1_o  = hit[0];
  assign busy2_o  = hit[1];
  assign idle_o   = empty[0] && empty[1] && !write_q;
  assign write_o  = write_q;
  assign wn_o     = wn_q;
  assign wd_o     = wd_q;
  assign hazard_o = haz_q;

  always_comb begin
    write_d = 1'b0;
    wn_d    = wn_q;
    wd_d    = wd_q;
    last_d  = last_q;
    haz_d   = haz_q
            | (push[0] && hit[2])
            | (push[1] && hit[3])
            | (&push && wn0_i != ZERO && wn0_i == wn1_i);
    if (|pop) begin
      write_d = hwn[gsel] != ZERO;
      wn_d    = hwn[gsel];
      wd_d    = hwd[gsel];
      last_d  = gsel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      wn_q    <= '0;
      wd_q    <= '0;
      last_q  <= 1'b1;
      haz_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      haz_q   <= haz_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, corner
// sequences and a queue-level reference model under random traffic.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, r0, v1, r1, wr, b1, b2, idle, haz;
  logic [4:0]  wn0, wn1, wn, rn1, rn2;
  logic [31:0] wd0, wd1, wd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .v0_i    (v0),
    .r0_o    (r0),
    .wn0_i   (wn0),
    .wd0_i   (wd0),
    .v1_i    (v1),
    .r1_o    (r1),
    .wn1_i   (wn1),
    .wd1_i   (wd1),
    .write_o (wr),
    .wn_o    (wn),
    .wd_o    (wd),
    .rn1_i   (rn1),
    .rn2_i   (rn2),
    .busy1_o (b1),
    .busy2_o (b2),
    .idle_o  (idle),
    .hazard_o(haz)
  );

  typedef struct {
    logic        v0;
    logic [4:0]  wn0;
    logic [31:0] wd0;
    logic        v1;
    logic [4:0]  wn1;
    logic [31:0] wd1;
    logic [4:0]  rn1;
    logic [4:0]  rn2;
    logic [43:0] exp;
  } vec_t;

  vec_t tbl[11];

  // Reference model state: plain queues of requests
  wb_req_t     mq0[$], mq1[$], sb0[$], sb1[$];
  logic        mw, mhaz;
  logic [4:0]  mwn;
  logic [31:0] mwd;
  int          mlast;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [43:0] outs();
    return {wr, wn, wd, r0, r1, b1, b2, idle, haz};
  endfunction

  function automatic logic [43:0] mkx(
    logic w, logic [4:0] n, logic [31:0] d, logic a, logic b,
    logic c, logic e, logic i, logic h);
    return {w, n, d, a, b, c, e, i, h};
  endfunction

  function automatic vec_t mkv(
    logic a, logic [4:0] b, logic [31:0] c, logic d,
    logic [4:0] e, logic [31:0] f, logic [4:0] g,
    logic [4:0] h, logic [43:0] x);
    vec_t t;
    t.v0 = a; t.wn0 = b; t.wd0 = c;
    t.v1 = d; t.wn1 = e; t.wd1 = f;
    t.rn1 = g; t.rn2 = h; t.exp = x;
    return t;
  endfunction

  task automatic drive(
    logic a, logic [4:0] b, logic [31:0] c, logic d,
    logic [4:0] e, logic [31:0] f, logic [4:0] g, logic [4:0] h);
    v0 = a; wn0 = b; wd0 = c;
    v1 = d; wn1 = e; wd1 = f;
    rn1 = g; rn2 = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic pend(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (mw && mwn == r) return 1'b1;
    foreach (mq0[k]) if (mq0[k].wn == r) return 1'b1;
    foreach (mq1[k]) if (mq1[k].wn == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    mq0.delete(); mq1.delete();
    sb0.delete(); sb1.delete();
    mw = 0; mwn = 0; mwd = 0; mlast = 1; mhaz = 0;
  endtask

  // Apply one edge of traffic to the model
  task automatic m_edge();
    logic    p0, p1;
    int      g;
    wb_req_t e;
    p0 = v0 && mq0.size() < DEPTH;
    p1 = v1 && mq1.size() < DEPTH;
    if ((p0 && pend(wn0)) || (p1 && pend(wn1))) mhaz = 1;
    if (p0 && p1 && wn0 != 0 && wn0 == wn1) mhaz = 1;
    g = -1;
    if (mq0.size() > 0 && mq1.size() > 0) g = 1 - mlast;
    else if (mq0.size() > 0) g = 0;
    else if (mq1.size() > 0) g = 1;
    mw = 0;
    if (g >= 0) begin
      e = (g == 0) ? mq0.pop_front() : mq1.pop_front();
      mw = e.wn != 0; mwn = e.wn; mwd = e.wd; mlast = g;
    end
    if (p0) begin
      e.wn = wn0; e.wd = wd0; mq0.push_back(e);
      if (wn0 != 0) sb0.push_back(e);
    end
    if (p1) begin
      e.wn = wn1; e.wd = wd1; mq1.push_back(e);
      if (wn1 != 0) sb1.push_back(e);
    end
  endtask

  initial begin
    logic [36:0] got[$];
    logic [36:0] want[8];
    logic        lo0, lo1, ok, mr0, mr1;
    int          i0, i1;

    tbl[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0,
                  mkx(0, 0, 0, 1, 1, 0, 0, 1, 0));
    tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 5, 0,
                  mkx(0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 5, 5,
                  mkx(1, 5, 32'hDEADBEEF, 1, 1, 1, 1, 0, 0));
    tbl[3]  = mkv(0, 0, 0, 1, 0, 32'h1234, 5, 0,
                  mkx(0, 5, 32'hDEADBEEF, 1, 1, 0, 0, 1, 0));
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,
                  mkx(0, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0));
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,
                  mkx(0, 0, 32'h1234, 1, 1, 0, 0, 1, 0));
    tbl[6]  = mkv(1, 7, 32'hA0A0, 0, 0, 0, 7, 0,
                  mkx(0, 0, 32'h1234, 1, 1, 0, 0, 1, 0));
    tbl[7]  = mkv(0, 0, 0, 1, 7, 32'hB0B0, 7, 0,
                  mkx(0, 0, 32'h1234, 1, 1, 1, 0, 0, 0));
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 7, 0,
                  mkx(1, 7, 32'hA0A0, 1, 1, 1, 0, 0, 1));
    tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 7, 0,
                  mkx(1, 7, 32'hB0B0, 1, 1, 1, 0, 0, 1));
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 7, 0,
                  mkx(0, 7, 32'hB0B0, 1, 1, 0, 0, 1, 1));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].wn0, tbl[i].wd0, tbl[i].v1,
            tbl[i].wn1, tbl[i].wd1, tbl[i].rn1, tbl[i].rn2);
      #4;
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
      tick();
    end

    // Both ports push back-to-back; writes must interleave
    do_reset();
    for (int k = 0; k < 4; k++) begin
      want[2*k]   = {5'(1 + k), 32'(100 + k)};
      want[2*k+1] = {5'(11 + k), 32'(200 + k)};
    end
    i0 = 0; i1 = 0; lo0 = 0; lo1 = 0;
    for (int c = 0; c < 40 && !(got.size() == 8 && idle); c++) begin
      drive(i0 < 4, 5'(1 + i0), 32'(100 + i0),
            i1 < 4, 5'(11 + i1), 32'(200 + i1), 0, 0);
      #4;
      if (!r0) lo0 = 1;
      if (!r1) lo1 = 1;
      if (wr) got.push_back({wn, wd});
      if (v0 && r0) i0++;
      if (v1 && r1) i1++;
      tick();
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_order%0d", k),
          64'(k < got.size() ? got[k] : 37'h0), 64'(want[k]));
    chk("rr_count", 64'(got.size()), 64'd8);
    chk("r0_backpressure", 64'(lo0), 64'd1);
    chk("r1_backpressure", 64'(lo1), 64'd1);

    // Reset while both queues hold work and Write is high
    do_reset();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'(20 + i0), 32'(i0),
            1, (i1 == 0) ? 5'd20 : 5'(25 + i1), 32'(i1), 0, 0);
      #4;
      if (r0) i0++;
      if (r1) i1++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 22, 27);
    #4;
    chk("pre_rst_write", 64'(wr), 64'd1);
    chk("pre_rst_hazard", 64'(haz), 64'd1);
    chk("pre_rst_busy", 64'({b1, b2}), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #4;
    chk("post_rst", 64'({wr, r0, r1, idle, haz, b1, b2}),
        64'(7'b0111000));
    drive(1, 3, 32'h33, 1, 4, 32'h44, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #4;
    chk("rst_first_grant", 64'({wr, wn, wd}), 64'({1'b1, 5'd3, 32'h33}));
    tick();
    #4;
    chk("rst_second_grant", 64'({wr, wn, wd}), 64'({1'b1, 5'd4, 32'h44}));
    tick();

    // Random traffic against the queue model and per-port scoreboard
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        m_reset();
        rst = 1'b0;
      end
      mr0 = mq0.size() < DEPTH;
      mr1 = mq1.size() < DEPTH;
      if (!(v0 && !mr0)) begin
        v0  = (i < 2980) && $urandom_range(0, 2) != 0;
        wn0 = 5'($urandom_range(0, 15));
        wd0 = $urandom;
      end
      if (!(v1 && !mr1)) begin
        v1  = (i < 2980) && $urandom_range(0, 2) != 0;
        wn1 = 5'($urandom_range(0, 15));
        wd1 = $urandom;
      end
      rn1 = 5'($urandom_range(0, 15));
      rn2 = 5'($urandom_range(0, 15));
      #4;
      chk("rand", 64'(outs()),
          64'({mw, mwn, mwd, mr0, mr1, pend(rn1), pend(rn2),
               mq0.size() == 0 && mq1.size() == 0 && !mw, mhaz}));
      if (wr) begin
        ok = 0;
        if (sb0.size() > 0 && sb0[0].wn == wn && sb0[0].wd == wd) begin
          void'(sb0.pop_front());
          ok = 1;
        end else if (sb1.size() > 0 && sb1[0].wn == wn &&
                     sb1[0].wd == wd) begin
          void'(sb1.pop_front());
          ok = 1;
        end
        chk("sb_order", 64'(ok), 64'd1);
      end
      m_edge();
      tick();
    end
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
